// File: rtl/usb_tx_pkt.sv
// usb_tx_pkt: host-side USB transmit packetizer. Builds token, ACK and data
// packets (SYNC prefix, CRC5/CRC16 suffix) and hands them byte-by-byte to the
// bit-level serializer over a valid/ready handshake. Incoming data bytes are
// absorbed by a small FIFO because the upstream sequencer cannot be throttled.
module usb_tx_pkt #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        c,
  input  logic        rst,
  input  logic        token_start,
  input  logic [18:0] token,
  input  logic        ack_start,
  input  logic [7:0]  txd,
  input  logic        txdv,
  output logic [7:0]  phy_d,
  output logic        phy_dv,
  output logic        phy_last,
  input  logic        phy_rdy,
  output logic        tx_sie_done,
  output logic        busy,
  output logic        ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SYNC   = 4'd1;
  localparam logic [3:0] S_PID    = 4'd2;
  localparam logic [3:0] S_TOK1   = 4'd3;
  localparam logic [3:0] S_TOK2   = 4'd4;
  localparam logic [3:0] S_DATA   = 4'd5;
  localparam logic [3:0] S_CRC_LO = 4'd6;
  localparam logic [3:0] S_CRC_HI = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [1:0] K_TOKEN = 2'd0;
  localparam logic [1:0] K_ACK   = 2'd1;
  localparam logic [1:0] K_DATA  = 2'd2;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] ACK_PID   = 8'hD2;

  logic [3:0]  state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [18:0] tok_q, tok_d;
  logic [15:0] crc_q, crc_d;
  logic        in_end_q, in_end_d;
  logic        txdv_q, txdv_d;
  logic        ovf_q, ovf_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  fifo_mem_q [FIFO_DEPTH];

  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  fifo_head;
  logic        fifo_we;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        wr_try;
  logic        data_start;

  // USB CRC5 over {endp, addr} sent LSB first; returns the complemented
  // remainder already bit-reversed so field bit 0 is the first bit on the wire.
  function automatic logic [4:0] crc5_field(input logic [10:0] bits);
    logic [4:0] r;
    logic       fb;
    logic [4:0] res;
    r = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb = bits[i] ^ r[4];
      r  = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'h05;
    end
    for (int i = 0; i < 5; i++) res[i] = ~r[4-i];
    return res;
  endfunction

  // USB CRC16 (poly 0x8005) in reflected form, one byte LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] r;
    r = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = {1'b0, r[15:1]} ^ 16'hA001;
      else      r = {1'b0, r[15:1]};
    end
    return r;
  endfunction

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head   = fifo_mem_q[rd_ptr_q[AW-1:0]];
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tx_sie_done = (state_q == S_DONE);
  assign ovf         = ovf_q;

  // Packet sequencing: request arbitration, byte selection and CRC accumulation.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    tok_d      = tok_q;
    crc_d      = crc_q;
    in_end_d   = in_end_q;
    phy_d      = 8'h00;
    phy_dv     = 1'b0;
    phy_last   = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    data_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        crc_d    = 16'hFFFF;
        in_end_d = 1'b0;
        if (token_start) begin
          state_d = S_SYNC;
          kind_d  = K_TOKEN;
          tok_d   = token;
        end else if (ack_start) begin
          state_d = S_SYNC;
          kind_d  = K_ACK;
        end else if (txdv && !txdv_q) begin
          state_d    = S_SYNC;
          kind_d     = K_DATA;
          data_start = 1'b1;
        end
      end
      S_SYNC: begin
        phy_d  = SYNC_BYTE;
        phy_dv = 1'b1;
        if (phy_rdy) state_d = S_PID;
      end
      S_PID: begin
        case (kind_q)
          K_TOKEN: begin
            phy_d  = tok_q[7:0];
            phy_dv = 1'b1;
            if (phy_rdy) state_d = S_TOK1;
          end
          K_ACK: begin
            phy_d    = ACK_PID;
            phy_dv   = 1'b1;
            phy_last = 1'b1;
            if (phy_rdy) state_d = S_DONE;
          end
          default: begin
            // Data PID is the first FIFO entry and is excluded from the CRC.
            phy_d  = fifo_empty ? 8'h00 : fifo_head;
            phy_dv = !fifo_empty;
            if (phy_rdy && !fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = S_DATA;
            end
          end
        endcase
      end
      S_TOK1: begin
        phy_d  = {tok_q[15], tok_q[14:8]};
        phy_dv = 1'b1;
        if (phy_rdy) state_d = S_TOK2;
      end
      S_TOK2: begin
        phy_d    = {crc5_field(tok_q[18:8]), tok_q[18:16]};
        phy_dv   = 1'b1;
        phy_last = 1'b1;
        if (phy_rdy) state_d = S_DONE;
      end
      S_DATA: begin
        if (!fifo_empty) begin
          phy_d  = fifo_head;
          phy_dv = 1'b1;
          if (phy_rdy) begin
            fifo_pop = 1'b1;
            crc_d    = crc16_byte(crc_q, fifo_head);
          end
        end else if (in_end_q) begin
          state_d = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        phy_d  = ~crc_q[7:0];
        phy_dv = 1'b1;
        if (phy_rdy) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        phy_d    = ~crc_q[15:8];
        phy_dv   = 1'b1;
        phy_last = 1'b1;
        if (phy_rdy) state_d = S_DONE;
      end
      S_DONE: begin
        fifo_flush = 1'b1;
        in_end_d   = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A falling txdv during a data packet marks the end of the input stream.
    if (busy && (kind_q == K_DATA) && txdv_q && !txdv) in_end_d = 1'b1;
  end

  // FIFO write acceptance, overflow detection and pointer updates.
  always_comb begin
    wr_try   = txdv && (data_start || (busy && (kind_q == K_DATA) && !in_end_q));
    fifo_we  = wr_try && !fifo_full;
    ovf_d    = ovf_q | (wr_try & fifo_full);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, fifo_we};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, fifo_pop};
    if (fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    txdv_d = txdv;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge c) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kind_q   <= K_TOKEN;
      in_end_q <= 1'b0;
      txdv_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      in_end_q <= in_end_d;
      txdv_q   <= txdv_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Datapath registers: token latch, running CRC and FIFO storage.
  always_ff @(posedge c) begin
    tok_q <= tok_d;
    crc_q <= crc_d;
    if (fifo_we) fifo_mem_q[wr_ptr_q[AW-1:0]] <= txd;
  end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Directed testbench for usb_tx_pkt: token, ACK, data, zero-length,
// overflow and mid-packet reset scenarios.
module tb_usb_tx_pkt;

  logic        c = 1'b0;
  logic        rst;
  logic        token_start;
  logic [18:0] token;
  logic        ack_start;
  logic [7:0]  txd;
  logic        txdv;
  logic [7:0]  phy_d;
  logic        phy_dv;
  logic        phy_last;
  logic        phy_rdy;
  logic        tx_sie_done;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cap_base;
  int done_base;
  logic [7:0] cap_d[$];
  logic       cap_l[$];
  logic [7:0] exp_q[$];
  logic [7:0] setup_b [9];
  logic [15:0] mcrc;

  usb_tx_pkt #(.FIFO_DEPTH(16)) dut (
    .c          (c),
    .rst        (rst),
    .token_start(token_start),
    .token      (token),
    .ack_start  (ack_start),
    .txd        (txd),
    .txdv       (txdv),
    .phy_d      (phy_d),
    .phy_dv     (phy_dv),
    .phy_last   (phy_last),
    .phy_rdy    (phy_rdy),
    .tx_sie_done(tx_sie_done),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 c = ~c;

  // Record every transferred byte and every done pulse.
  always @(negedge c) begin
    if (phy_dv && phy_rdy) begin
      cap_d.push_back(phy_d);
      cap_l.push_back(phy_last);
    end
    if (tx_sie_done) done_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Bit-serial USB CRC16, MSB-feedback form, data bits LSB first.
  function automatic logic [15:0] crc16_add(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = crc;
    for (int i = 0; i < 8; i++) begin
      fb = b[i] ^ r[15];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h8005;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge c);
    #1;
  endtask

  task automatic at_neg();
    @(negedge c);
  endtask

  task automatic begin_pkt();
    cap_base  = cap_d.size();
    done_base = done_cnt;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge c);
    while (!tx_sie_done && n < 80) begin
      @(negedge c);
      n++;
    end
    check({tag, "_done"}, 32'(tx_sie_done), 1);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask

  task automatic check_pkt(input string tag);
    int n;
    n = cap_d.size() - cap_base;
    check({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i),
            (i < n) ? 32'(cap_d[cap_base + i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i),
            (i < n) ? 32'(cap_l[cap_base + i]) : 32'hFFFF_FFFF, 32'(i == exp_q.size() - 1));
    end
    check({tag, "_done_pulses"}, done_cnt - done_base, 1);
  endtask

  initial begin
    rst = 1'b1;
    token_start = 1'b0;
    ack_start = 1'b0;
    token = '0;
    txd = '0;
    txdv = 1'b0;
    phy_rdy = 1'b1;
    setup_b = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};

    repeat (3) cyc();
    at_neg();
    check("rst_phy_d", 32'(phy_d), 0);
    check("rst_phy_dv", 32'(phy_dv), 0);
    check("rst_phy_last", 32'(phy_last), 0);
    check("rst_done", 32'(tx_sie_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // SETUP token addr 0 endp 0
    begin_pkt();
    token = {4'd0, 7'd0, 8'h2D};
    token_start = 1'b1;
    cyc();
    token_start = 1'b0;
    at_neg();
    check("t1_busy", 32'(busy), 1);
    check("t1_dv", 32'(phy_dv), 1);
    check("t1_sync", 32'(phy_d), 32'h80);
    cyc();
    wait_done("t1");
    cyc();
    exp_q = '{8'h80, 8'h2D, 8'h00, 8'h10};
    check_pkt("t1");

    // IN token addr 1 with phy_rdy toggling
    begin_pkt();
    phy_rdy = 1'b0;
    token = {4'd0, 7'd1, 8'h69};
    token_start = 1'b1;
    cyc();
    token_start = 1'b0;
    exp_q = '{8'h80, 8'h69, 8'h01, 8'hE8};
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check($sformatf("t2_hold%0d_dv", k), 32'(phy_dv), 1);
      check($sformatf("t2_hold%0d_d", k), 32'(phy_d), 32'(exp_q[k]));
      cyc();
      phy_rdy = 1'b1;
      at_neg();
      check($sformatf("t2_stable%0d_d", k), 32'(phy_d), 32'(exp_q[k]));
      check($sformatf("t2_stable%0d_last", k), 32'(phy_last), 32'(k == 3));
      cyc();
      phy_rdy = 1'b0;
    end
    at_neg();
    check("t2_done", 32'(tx_sie_done), 1);
    check("t2_busy_at_done", 32'(busy), 0);
    phy_rdy = 1'b1;
    cyc();
    check_pkt("t2");

    // 9-byte SETUP data burst streamed while transmitting
    begin_pkt();
    txdv = 1'b1;
    txd = setup_b[0];
    for (int i = 1; i < 9; i++) begin
      cyc();
      txd = setup_b[i];
      if (i == 1) begin
        at_neg();
        check("t3_busy", 32'(busy), 1);
        check("t3_sync", 32'(phy_d), 32'h80);
      end
    end
    cyc();
    txdv = 1'b0;
    txd = 8'h00;
    wait_done("t3");
    cyc();
    exp_q = '{8'h80, 8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    check_pkt("t3");

    // zero-length data packet
    begin_pkt();
    txdv = 1'b1;
    txd = 8'hC3;
    cyc();
    txdv = 1'b0;
    txd = 8'h00;
    wait_done("t4");
    cyc();
    exp_q = '{8'h80, 8'hC3, 8'h00, 8'h00};
    check_pkt("t4");

    // token wins over simultaneous ACK; request during DONE is ignored
    begin_pkt();
    token = {4'd0, 7'd0, 8'hE1};
    token_start = 1'b1;
    ack_start = 1'b1;
    cyc();
    token_start = 1'b0;
    ack_start = 1'b0;
    wait_done("t5");
    ack_start = 1'b1;
    cyc();
    ack_start = 1'b0;
    at_neg();
    check("t5_done_req_busy", 32'(busy), 0);
    check("t5_done_req_dv", 32'(phy_dv), 0);
    cyc();
    exp_q = '{8'h80, 8'hE1, 8'h00, 8'h10};
    check_pkt("t5");

    begin_pkt();
    ack_start = 1'b1;
    cyc();
    ack_start = 1'b0;
    wait_done("t5a");
    cyc();
    at_neg();
    check("t5a_busy_after", 32'(busy), 0);
    cyc();
    exp_q = '{8'h80, 8'hD2};
    check_pkt("t5a");

    // FIFO_DEPTH+4 byte burst with serializer stalled
    begin_pkt();
    phy_rdy = 1'b0;
    txdv = 1'b1;
    txd = 8'h4B;
    for (int i = 1; i < 20; i++) begin
      cyc();
      txd = 8'(i);
    end
    cyc();
    txdv = 1'b0;
    txd = 8'h00;
    at_neg();
    check("t6_ovf", 32'(ovf), 1);
    check("t6_stalled_sync", 32'(phy_d), 32'h80);
    cyc();
    phy_rdy = 1'b1;
    wait_done("t6");
    cyc();
    exp_q = '{8'h80, 8'h4B};
    mcrc = 16'hFFFF;
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back(8'(i));
      mcrc = crc16_add(mcrc, 8'(i));
    end
    mcrc = ~mcrc;
    exp_q.push_back({<<{mcrc[15:8]}});
    exp_q.push_back({<<{mcrc[7:0]}});
    check_pkt("t6");
    at_neg();
    check("t6_ovf_sticky", 32'(ovf), 1);

    // reset in the middle of a data packet
    cyc();
    begin_pkt();
    txdv = 1'b1;
    txd = 8'hC3;
    cyc();
    txd = 8'h11;
    cyc();
    txd = 8'h22;
    cyc();
    txdv = 1'b0;
    txd = 8'h00;
    rst = 1'b1;
    at_neg();
    check("t7_mid_busy", 32'(busy), 1);
    cyc();
    at_neg();
    check("t7_rst_phy_d", 32'(phy_d), 0);
    check("t7_rst_phy_dv", 32'(phy_dv), 0);
    check("t7_rst_phy_last", 32'(phy_last), 0);
    check("t7_rst_done", 32'(tx_sie_done), 0);
    check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    repeat (6) cyc();
    check("t7_no_done", done_cnt - done_base, 0);

    // recovery after reset
    begin_pkt();
    token = {4'd0, 7'd1, 8'h69};
    token_start = 1'b1;
    cyc();
    token_start = 1'b0;
    wait_done("t8");
    cyc();
    exp_q = '{8'h80, 8'h69, 8'h01, 8'hE8};
    check_pkt("t8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
